// File: rtl/cpu_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide with fixed latency.
module cpu_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            div_by_zero_o
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   m_q, m_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   fix_res_q, fix_res_d;
    logic              fix_dbz_q, fix_dbz_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              dbz_q, dbz_d;

    logic              sgn_a, sgn_b;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     add_w;
    logic [XLEN:0]     sh_w;
    logic [XLEN:0]     dif_w;
    logic [2*XLEN-1:0] prod_w;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_w;
    logic [XLEN-1:0]   rem_w;

    always_comb begin
        sgn_a  = (op_q == 3'b001) || (op_q == 3'b010) ||
                 (op_q == 3'b100) || (op_q == 3'b110);
        sgn_b  = (op_q == 3'b001) || (op_q == 3'b100) ||
                 (op_q == 3'b110);
        neg_a  = sgn_a & a_q[XLEN-1];
        neg_b  = sgn_b & b_q[XLEN-1];
        abs_a  = neg_a ? (~a_q + 1'b1) : a_q;
        abs_b  = neg_b ? (~b_q + 1'b1) : b_q;
        // hi holds the running partial product / partial remainder
        add_w  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        sh_w   = {hi_q, lo_q[XLEN-1]};
        dif_w  = sh_w - {1'b0, m_q};
        prod_w = {hi_q, lo_q};
        prod_s = neg_q ? (~prod_w + 1'b1) : prod_w;
        quo_w  = neg_q ? (~lo_q + 1'b1) : lo_q;
        rem_w  = rneg_q ? (~hi_q + 1'b1) : hi_q;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        fix_res_d = fix_res_q;
        fix_dbz_d = fix_dbz_q;
        done_d    = 1'b0;
        result_d  = result_q;
        dbz_d     = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !done_q) begin
                    state_d = S_PREP;
                    op_d    = op_i;
                    a_d     = rs1_i;
                    b_d     = rs2_i;
                end
            end
            S_PREP: begin
                hi_d   = '0;
                cnt_d  = CNT_W'(XLEN);
                neg_d  = neg_a ^ neg_b;
                rneg_d = neg_a;
                if (op_q[2]) begin
                    lo_d = abs_a;
                    m_d  = abs_b;
                end else begin
                    lo_d = abs_b;
                    m_d  = abs_a;
                end
                state_d = S_CALC;
            end
            S_CALC: begin
                cnt_d = cnt_q - 1'b1;
                if (op_q[2]) begin
                    if (!dif_w[XLEN]) begin
                        hi_d = dif_w[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = sh_w[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    hi_d = add_w[XLEN:1];
                    lo_d = {add_w[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                fix_dbz_d = 1'b0;
                if (op_q[2]) begin
                    if (b_q == '0) begin
                        fix_res_d = op_q[1] ? a_q : '1;
                        fix_dbz_d = 1'b1;
                    end else begin
                        fix_res_d = op_q[1] ? rem_w : quo_w;
                    end
                end else if (op_q[1:0] == 2'b00) begin
                    fix_res_d = prod_s[XLEN-1:0];
                end else begin
                    fix_res_d = prod_s[2*XLEN-1:XLEN];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d   = 1'b1;
                result_d = fix_res_q;
                dbz_d    = fix_dbz_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort keeps the previously published result
        if (flush_i) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
            dbz_d    = dbz_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            fix_res_q <= '0;
            fix_dbz_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            fix_res_q <= fix_res_d;
            fix_dbz_q <= fix_dbz_d;
            done_q    <= done_d;
            result_q  <= result_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy_o        = (state_q == S_PREP) || (state_q == S_CALC) ||
                           (state_q == S_FIX);
    assign done_o        = done_q;
    assign result_o      = result_q;
    assign div_by_zero_o = dbz_q;

endmodule
